// File: rtl/riscv_regfile_wb_if.sv
// Write-back, issue and read-port bundle for the integer register file.
// The master side is the pipeline (stage 9 write-back, decode/issue); the slave side is the register file.
interface riscv_regfile_wb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            wb_valid;
  logic [AW-1:0]   wb_rd_addr;
  logic [XLEN-1:0] wb_data;

  logic            rd_req;
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            rd_valid;

  logic            iss_valid;
  logic [AW-1:0]   iss_rd_addr;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output wb_valid, wb_rd_addr, wb_data,
    output rd_req, rs1_addr, rs2_addr,
    output iss_valid, iss_rd_addr,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid, busy_vec
  );

  modport slave (
    input  wb_valid, wb_rd_addr, wb_data,
    input  rd_req, rs1_addr, rs2_addr,
    input  iss_valid, iss_rd_addr,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, rd_valid, busy_vec
  );
endinterface

// File: rtl/riscv_regfile_wb.sv
// Integer register file with one write-back port, two registered read ports
// (write-first bypass) and an in-flight scoreboard of pending destinations.
module riscv_regfile_wb #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input logic               clk,
  input logic               rst_n,
  riscv_regfile_wb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic        BYP = (BYPASS_EN != 0);

  // x0 has no storage; index 0 is never written or read.
  logic [XLEN-1:0]  r_regs [1:NREGS-1];
  logic [NREGS-1:1] r_busy;
  logic [NREGS-1:1] w_busy_nxt;

  logic [XLEN-1:0]  r_rs1_data, r_rs2_data;
  logic             r_rs1_busy, r_rs2_busy;
  logic             r_rd_valid;

  logic [XLEN-1:0]  w_rs1_data, w_rs2_data;
  logic             w_rs1_busy, w_rs2_busy;
  logic             w_wb_en;
  logic             w_iss_en;
  logic             w_fwd1, w_fwd2;

  assign w_wb_en  = bus.wb_valid  && (bus.wb_rd_addr  != '0);
  assign w_iss_en = bus.iss_valid && (bus.iss_rd_addr != '0);
  assign w_fwd1   = BYP && w_wb_en && (bus.wb_rd_addr == bus.rs1_addr);
  assign w_fwd2   = BYP && w_wb_en && (bus.wb_rd_addr == bus.rs2_addr);

  always_ff @(posedge clk) begin
    if (w_wb_en)
      r_regs[bus.wb_rd_addr] <= bus.wb_data;
  end

  always_comb begin
    w_rs1_data = '0;
    w_rs1_busy = 1'b0;
    if (bus.rs1_addr != '0) begin
      w_rs1_data = w_fwd1 ? bus.wb_data : r_regs[bus.rs1_addr];
      w_rs1_busy = r_busy[bus.rs1_addr] && !w_fwd1;
    end
  end

  always_comb begin
    w_rs2_data = '0;
    w_rs2_busy = 1'b0;
    if (bus.rs2_addr != '0) begin
      w_rs2_data = w_fwd2 ? bus.wb_data : r_regs[bus.rs2_addr];
      w_rs2_busy = r_busy[bus.rs2_addr] && !w_fwd2;
    end
  end

  // Set is applied after clear so a same-edge issue of a younger writer wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wb_en)
      w_busy_nxt[bus.wb_rd_addr] = 1'b0;
    if (w_iss_en)
      w_busy_nxt[bus.iss_rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_rd_valid <= 1'b0;
      r_rs1_busy <= 1'b0;
      r_rs2_busy <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rs1_busy <= w_rs1_busy;
        r_rs2_busy <= w_rs2_busy;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.rd_req) begin
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
    end
  end

  assign bus.rs1_data = r_rs1_data;
  assign bus.rs2_data = r_rs2_data;
  assign bus.rs1_busy = r_rs1_busy;
  assign bus.rs2_busy = r_rs2_busy;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy_vec = {r_busy, 1'b0};

endmodule

// File: doc/riscv_regfile_wb.md
Name: riscv_regfile_wb

Overview:
- Integer register file for the 10-stage pipeline: x0..x31, 32-bit.
- Consumes the write-back interface produced by stage 9. It has one write port driven by wb_valid/wb_rd_addr/wb_data, and two registered read ports for decode/issue.
- Holds an in-flight scoreboard. Issue sets a pending bit per destination register; write-back clears it. Read ports report both data and pending status.
- Targets the 2 GHz budget: reads are registered, one cycle of latency, with write-first bypass.

Parameters:
- XLEN, 32, data width of each register and of the write/read data ports.
- NREGS, 32, number of architectural registers; address width is $clog2(NREGS).
- BYPASS_EN, 1, when 1, a same-cycle write to a read address is forwarded to the read result (write-first); when 0, the read returns the old array value.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  write-back request this cycle
- wb_rd_addr  in  5  write-back destination register
- wb_data  in  XLEN  write-back data
- rd_req  in  1  read request; samples rs1_addr/rs2_addr
- rs1_addr  in  5  read port 1 address
- rs2_addr  in  5  read port 2 address
- rs1_data  out  XLEN  read port 1 result, valid when rd_valid
- rs2_data  out  XLEN  read port 2 result, valid when rd_valid
- rs1_busy  out  1  rs1 had a write pending (not yet written back) at the read sample point
- rs2_busy  out  1  same for rs2
- rd_valid  out  1  rs*_data/rs*_busy valid this cycle
- iss_valid  in  1  an instruction writing iss_rd_addr is issued this cycle
- iss_rd_addr  in  5  destination register of the issued instruction
- busy_vec  out  NREGS  current scoreboard (debug/perf), bit 0 always 0

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-low (rst_n), as fixed for this block.
- Reset: asserting rst_n low forces the following, at any time including mid-operation:
  - rd_valid=0, busy_vec=0, rs1_busy=0, rs2_busy=0.
  - Register array contents are NOT reset (data path). Their values after reset are undefined, except x0.
  - rs1_data/rs2_data are not reset. They are undefined until the first rd_valid.
- Write: on a posedge with wb_valid=1 and wb_rd_addr!=0, regs[wb_rd_addr]<=wb_data. wb_valid with wb_rd_addr=0 is a no-op.
- x0: always reads 0. It never sets busy. Its busy bit is hardwired 0.
- Read latency 1. rd_req sampled at edge N drives rd_valid=1 at N+1 (registered).
  - rd_req=0 gives rd_valid=0 next cycle.
  - The data outputs hold their last value when no new read is sampled.
- Read value for port k, addr a, sampled at edge N:
  - a==0: 0.
  - BYPASS_EN=1 and wb_valid=1 and wb_rd_addr==a at the same edge: wb_data.
  - Otherwise: regs[a] before edge N.
- Both ports may read the same address. Both receive identical data and busy.
- Scoreboard: busy_q[NREGS-1:1], registered, updated each edge.
  - Clear: wb_valid=1 and wb_rd_addr!=0 clears busy_q[wb_rd_addr].
  - Set: iss_valid=1 and iss_rd_addr!=0 sets busy_q[iss_rd_addr].
  - Same address set and clear at the same edge: the set wins, so the bit ends at 1 (younger writer in flight).
  - Set of an already-busy bit: stays 1. Clear of an idle bit: stays 0. There is no counting; one writer per register in flight is guaranteed by issue.
- Busy read, port k, addr a, sampled at edge N (registered to N+1):
  - rsk_busy = busy_q[a] & ~(wb_valid & wb_rd_addr==a), with the wb term masked when BYPASS_EN=0.
  - A same-edge issue of a does not set rsk_busy; that issue is younger than the reader.
  - a==0 gives 0.
- busy_vec is the registered busy_q with bit 0 = 0.
- No backpressure. Write and read are always accepted.

Test Plan:
- Reset with rst_n=0 mid-stream and iss_valid=1 to x5 → busy_vec=0 and rd_valid=0 immediately, with no clk edge needed; both remain 0 for the cycle after release.
- Write x7=0xDEADBEEF, next cycle rd_req with rs1=7, rs2=0 → one cycle later rd_valid=1, rs1_data=0xDEADBEEF, rs2_data=0, both busy=0.
- Same-cycle wb_valid x3=0x12345678 with rd_req rs1=3, rs2=3, prior x3=0x1 → rs1_data=rs2_data=0x12345678 (BYPASS_EN=1); with BYPASS_EN=0 → 0x1 and the following read → 0x12345678.
- wb_valid to x0 with data 0xFFFFFFFF, then read rs1=0 → rs1_data=0; iss_valid to x0 → busy_vec[0]=0.
- Scoreboard sequence:
  - Issue x9 → busy_vec[9]=1. Read rs1=9 → rs1_busy=1.
  - wb x9 and read rs1=9 in the same cycle → rs1_busy=0, data=wb_data, busy_vec[9]=0.
- Simultaneous iss_valid x4 and wb_valid x4 with busy_vec[4]=1 → busy_vec[4] stays 1; a read of x4 at that edge returns rs1_busy=0 and the wb data.
